// File: rtl/demux_reg_if.sv
// Handshake bundle for demux_reg: the source port, the two destination channels and the delivery counters.
interface demux_reg_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_sel;
  logic               a_valid;
  logic               a_ready;
  logic [WIDTH-1:0]   a_data;
  logic               b_valid;
  logic               b_ready;
  logic [WIDTH-1:0]   b_data;
  logic [COUNT_W-1:0] a_count;
  logic [COUNT_W-1:0] b_count;

  // Environment side: drives the source word and both consumer readies.
  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );
endinterface

// File: rtl/demux_reg.sv
// Registered 1-to-2 demultiplexer: steers one source word into channel A or B,
// each with its own holding register, valid/ready handshake and delivery counter.
module demux_reg #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 8
) (
  input logic        CLK,
  input logic        reset,
  demux_reg_if.slave bus
);
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t             r_a_state, w_a_state_nxt;
  state_t             r_b_state, w_b_state_nxt;
  logic [WIDTH-1:0]   r_a_data, r_b_data;
  logic [COUNT_W-1:0] r_a_count, r_b_count;

  logic w_a_full, w_b_full;
  logic w_a_drain, w_b_drain;
  logic w_in_ready, w_acc;
  logic w_a_load, w_b_load;

  assign w_a_full  = (r_a_state == S_FULL);
  assign w_b_full  = (r_b_state == S_FULL);
  assign w_a_drain = w_a_full & bus.a_ready;
  assign w_b_drain = w_b_full & bus.b_ready;

  // Readiness looks only at the selected channel so a stall on one never blocks the other.
  assign w_in_ready = bus.in_sel ? (~w_b_full | bus.b_ready) : (~w_a_full | bus.a_ready);
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_a_load   = w_acc & ~bus.in_sel;
  assign w_b_load   = w_acc &  bus.in_sel;

  always_comb begin
    w_a_state_nxt = r_a_state;
    w_b_state_nxt = r_b_state;
    case (r_a_state)
      S_EMPTY: if (w_a_load)              w_a_state_nxt = S_FULL;
      S_FULL:  if (w_a_drain & ~w_a_load) w_a_state_nxt = S_EMPTY;
      default:                            w_a_state_nxt = S_EMPTY;
    endcase
    case (r_b_state)
      S_EMPTY: if (w_b_load)              w_b_state_nxt = S_FULL;
      S_FULL:  if (w_b_drain & ~w_b_load) w_b_state_nxt = S_EMPTY;
      default:                            w_b_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_a_state <= S_EMPTY;
      r_b_state <= S_EMPTY;
    end else begin
      r_a_state <= w_a_state_nxt;
      r_b_state <= w_b_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_a_data <= '0;
      r_b_data <= '0;
    end else begin
      if (w_a_load) r_a_data <= bus.in_data;
      if (w_b_load) r_b_data <= bus.in_data;
    end
  end

  // Counters wrap freely; the width sets the modulus.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_a_drain) r_a_count <= r_a_count + 1'b1;
      if (w_b_drain) r_b_count <= r_b_count + 1'b1;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.a_valid  = w_a_full;
  assign bus.b_valid  = w_b_full;
  assign bus.a_data   = r_a_data;
  assign bus.b_data   = r_b_data;
  assign bus.a_count  = r_a_count;
  assign bus.b_count  = r_b_count;
endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: a vector table for the basic routing/stall cases
// plus hand-written sequences for stall hold, streaming, counter wrap and mid-operation reset.
module tb_demux_reg;
  logic CLK;
  logic reset;
  int unsigned checks;
  int unsigned failures;

  demux_reg_if #(.WIDTH(16), .COUNT_W(8)) bus ();

  demux_reg #(.WIDTH(16), .COUNT_W(8)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic        sel;
    logic [15:0] d;
    logic        ar;
    logic        br;
    logic        e_rdy;
    logic        e_av;
    logic [15:0] e_ad;
    logic        e_bv;
    logic [15:0] e_bd;
    logic [7:0]  e_ac;
    logic [7:0]  e_bc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic sel, input logic [15:0] d,
                       input logic ar, input logic br);
    bus.in_valid = iv;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic av, input logic [15:0] ad,
                           input logic bv, input logic [15:0] bd,
                           input logic [7:0] ac, input logic [7:0] bc);
    chk({nm, ".a_valid"}, 32'(bus.a_valid), 32'(av));
    chk({nm, ".a_data"},  32'(bus.a_data),  32'(ad));
    chk({nm, ".b_valid"}, 32'(bus.b_valid), 32'(bv));
    chk({nm, ".b_data"},  32'(bus.b_data),  32'(bd));
    chk({nm, ".a_count"}, 32'(bus.a_count), 32'(ac));
    chk({nm, ".b_count"}, 32'(bus.b_count), 32'(bc));
  endtask

  logic [7:0] exp_bc;
  logic [7:0] prev_bc;
  logic       saw_wrap;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // route A, drain; send B with B stalled; reject a B word; load and drain A under B stall
    vecs[0] = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 8'd0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0000, 8'd1, 8'd0};
    vecs[2] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1, 16'hBEEF, 8'd1, 8'd0};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 16'hBEEF, 8'd1, 8'd0};
    vecs[4] = '{1'b1, 1'b0, 16'h0A0A, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0A0A, 1'b1, 16'hBEEF, 8'd1, 8'd0};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0A0A, 1'b1, 16'hBEEF, 8'd2, 8'd0};

    // Test 1: asynchronous reset between clock edges
    #12;
    reset = 1'b1;
    #1;
    chk_state("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0);
    bus.in_sel = 1'b0;
    #1;
    chk("reset.in_ready_sel0", 32'(bus.in_ready), 32'd1);
    bus.in_sel = 1'b1;
    #1;
    chk("reset.in_ready_sel1", 32'(bus.in_ready), 32'd1);
    @(negedge CLK);
    reset = 1'b0;
    tick();

    // Tests 2-3: table-driven routing and stall isolation
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].ar, vecs[i].br);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].e_av, vecs[i].e_ad, vecs[i].e_bv,
                vecs[i].e_bd, vecs[i].e_ac, vecs[i].e_bc);
    end

    // B stays stalled with a competing word offered: data must not move
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'h7777, 1'b1, 1'b0);
      #1;
      chk($sformatf("stall%0d.in_ready", i), 32'(bus.in_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d.b_valid", i), 32'(bus.b_valid), 32'd1);
      chk($sformatf("stall%0d.b_data", i), 32'(bus.b_data), 32'hBEEF);
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    chk_state("unstall", 1'b0, 16'h0A0A, 1'b0, 16'hBEEF, 8'd2, 8'd1);

    // Test 4: back-to-back streaming into A
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'(i), 1'b1, 1'b1);
      #1;
      chk($sformatf("stream%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      chk($sformatf("stream%0d.a_valid", i), 32'(bus.a_valid), 32'd1);
      chk($sformatf("stream%0d.a_data", i), 32'(bus.a_data), 32'(i));
      chk($sformatf("stream%0d.a_count", i), 32'(bus.a_count), 32'(2 + i));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    chk_state("stream_end", 1'b0, 16'h0007, 1'b0, 16'hBEEF, 8'd10, 8'd1);

    // Test 5: 256 words streamed through B, counter must wrap 255 -> 0
    exp_bc   = 8'd1;
    saw_wrap = 1'b0;
    for (int k = 0; k < 256; k++) begin
      prev_bc = bus.b_count;
      drive(1'b1, 1'b1, 16'(k), 1'b1, 1'b1);
      tick();
      if (k > 0) exp_bc = exp_bc + 8'd1;
      if (prev_bc == 8'd255 && bus.b_count == 8'd0) saw_wrap = 1'b1;
      chk($sformatf("wrap%0d.b_count", k), 32'(bus.b_count), 32'(exp_bc));
      chk($sformatf("wrap%0d.b_data", k), 32'(bus.b_data), 32'(k));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    chk("wrap.saw_wrap", 32'(saw_wrap), 32'd1);
    chk_state("wrap_end", 1'b0, 16'h0007, 1'b0, 16'h00FF, 8'd10, 8'd1);

    // Test 6: reset while A holds a stalled word
    drive(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("mid.a_valid_pre", 32'(bus.a_valid), 32'd1);
    chk("mid.a_data_pre", 32'(bus.a_data), 32'h5555);
    #3;
    reset = 1'b1;
    #1;
    chk_state("mid_reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 8'd0);
    #2;
    reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid.idle_a_valid", 32'(bus.a_valid), 32'd0);
    drive(1'b1, 1'b0, 16'h00C3, 1'b1, 1'b1);
    tick();
    chk_state("post_reset_load", 1'b1, 16'h00C3, 1'b0, 16'h0000, 8'd0, 8'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    chk_state("post_reset_drain", 1'b0, 16'h00C3, 1'b0, 16'h0000, 8'd1, 8'd0);

    // Simultaneous drain on both channels increments both counters
    drive(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'h0022, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    chk_state("dual_drain", 1'b0, 16'h0011, 1'b0, 16'h0022, 8'd2, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/demux_reg.md
Name: demux_reg

Overview:
- Registered 1-to-2 demultiplexer: the routing counterpart of the datapath 2:1 mux.
- Takes one WIDTH-bit source word plus a select bit.
- Steers the word into one of two independent output holding registers (channel A, channel B).
- Each channel has a valid/ready handshake, so either consumer may stall without blocking the other.
- Sits between the ALU/bus result path and the two destination units: register-file write port (A) and memory/IO write path (B).

Parameters:
- WIDTH, 16, data width of input and both outputs.
- COUNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a word.
- in_ready  output  1  demux can accept the word this cycle (combinational).
- in_data  input  WIDTH  source word.
- in_sel  input  1  destination select: 0 = channel A, 1 = channel B.
- a_valid  output  1  channel A holding register occupied.
- a_ready  input  1  channel A consumer accepts.
- a_data  output  WIDTH  channel A word.
- b_valid  output  1  channel B holding register occupied.
- b_ready  input  1  channel B consumer accepts.
- b_data  output  WIDTH  channel B word.
- a_count  output  COUNT_W  words delivered on channel A (handshakes completed).
- b_count  output  COUNT_W  words delivered on channel B.

Behaviour:
- Reset, asynchronous and immediate, independent of CLK:
  - a_valid = b_valid = 0.
  - a_data = b_data = 0.
  - a_count = b_count = 0.
  - Any held word is discarded. No partial transfer survives a mid-operation reset.
- Each channel x is a two-state machine: EMPTY (x_valid=0) and FULL (x_valid=1).
- Drain: x_drain = x_valid & x_ready.
- Ready rule (combinational, no registered stall):
  - in_ready = in_sel ? (!b_valid | b_ready) : (!a_valid | a_ready).
  - in_ready depends only on the selected channel. A stalled B never blocks a word bound for A, and vice versa.
- Accept: acc = in_valid & in_ready.
  - Next edge: target x_data <= in_data and x_valid <= 1.
  - Latency is 1 cycle from accept to x_valid.
  - The non-selected channel is unchanged.
- EMPTY -> FULL on a load.
- FULL -> EMPTY on x_drain with no load into x in the same cycle.
- FULL stays FULL when x_drain and a load into x occur in the same cycle:
  - x_data is replaced with the new word.
  - Sustained throughput is 1 word/cycle per channel.
- FULL with x_ready=0: x_data and x_valid hold stable until handshake. Stability is mandatory.
- x_valid never depends combinationally on x_ready.
- in_data is sampled only on acc. When in_valid=0, or the word is rejected, data is ignored.
- in_sel is significant only when in_valid=1.
- Counters:
  - x_count increments by 1 on each edge where x_drain=1.
  - Wraps modulo 2^COUNT_W: 255 -> 0 at default.
  - No saturation, no overflow flag.
- Simultaneous events:
  - A load into A and a drain of B in the same cycle are fully independent.
  - A drain on both channels in the same cycle increments both counters.
- A source that holds in_valid with in_ready=0 has its word taken on the first cycle in_ready rises. No word is duplicated or lost.

Test Plan:
1. Reset then idle:
   - Assert reset asynchronously mid-cycle with no clock edge.
   - All valids, data and counts read 0 immediately.
   - in_ready=1 for both sel values.
2. Single route:
   - in_valid=1, in_sel=0, in_data=16'h1234, a_ready=1, for one cycle.
   - a_valid=1, a_data=16'h1234 on the next cycle.
   - Then a_valid=0, a_count=1.
   - b_valid stays 0 throughout.
3. Stall isolation:
   - b_ready=0; send 16'hBEEF to B, then 16'h0A0A to A.
   - B holds 16'hBEEF stable across 10 cycles.
   - With in_sel=1, in_ready=0.
   - The A word is accepted and delivered (a_count=1) while B is stalled.
4. Back-to-back streaming:
   - 8 consecutive words 0..7 to A with a_ready=1 throughout.
   - in_ready=1 every cycle.
   - a_data shows 0..7 on consecutive cycles; a_count=8.
5. Counter wrap:
   - 256 delivered words on B.
   - b_count goes 255 -> 0.
   - Channel A counter is unaffected.
6. Reset mid-operation:
   - A FULL with 16'h5555 and a_ready=0; pulse reset.
   - a_valid=0 and a_count=0 immediately.
   - After release, the next word to A is delivered normally with no stale 16'h5555.
